// File: rtl/banked_mem_reader_pkg.sv
// Shared types and default widths for the banked memory reader and its bank register.
package banked_mem_reader_pkg;

  localparam int BANK_W_DEF = 2;
  localparam int ADDR_W_DEF = 6;
  localparam int DATA_W_DEF = 8;
  localparam int RD_CNT_W   = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } rd_state_e;

endpackage

// File: rtl/banked_mem_reader_if.sv
// Request, memory and response signals of the banked reader; slave is the reader's view.
interface banked_mem_reader_if
  import banked_mem_reader_pkg::*;
#(
  parameter int BANK_W = BANK_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);

  logic                     req_valid;
  logic [ADDR_W-1:0]        req_addr;
  logic                     req_ready;
  logic                     mem_re;
  logic [BANK_W+ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0]        mem_rdata;
  logic                     rsp_valid;
  logic [DATA_W-1:0]        rsp_data;
  logic                     rsp_ready;

  modport slave (
    input  req_valid, req_addr, mem_rdata, rsp_ready,
    output req_ready, mem_re, mem_addr, rsp_valid, rsp_data
  );

  modport master (
    output req_valid, req_addr, mem_rdata, rsp_ready,
    input  req_ready, mem_re, mem_addr, rsp_valid, rsp_data
  );

endinterface

// File: rtl/banked_mem_reader_bank_reg.sv
// Bank-select holding register: loads on clock enable, clears on reset.
module banked_mem_reader_bank_reg
  import banked_mem_reader_pkg::*;
#(
  parameter int W = BANK_W_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_ce,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_q;

  // Bank value capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= {W{1'b0}};
    end else if (i_ce) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/banked_mem_reader.sv
// Single-outstanding reader: latches bank/address, issues one synchronous memory
// read, then holds the returned word until the consumer takes it.
module banked_mem_reader
  import banked_mem_reader_pkg::*;
#(
  parameter int BANK_W = BANK_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [BANK_W-1:0]   i_bank,
  banked_mem_reader_if.slave  bus,
  output logic [RD_CNT_W-1:0] o_rd_count
);

  rd_state_e             r_state;
  rd_state_e             w_next_state;
  logic [ADDR_W-1:0]     r_addr_q;
  logic [DATA_W-1:0]     r_data_q;
  logic [RD_CNT_W-1:0]   r_rd_count;
  logic [BANK_W-1:0]     w_bank_q;
  logic                  w_accept;
  logic                  w_rsp_done;

  assign w_accept   = bus.req_valid && (r_state == ST_IDLE);
  assign w_rsp_done = bus.rsp_ready && (r_state == ST_RESP);

  banked_mem_reader_bank_reg #(
    .W (BANK_W)
  ) u_bank_reg (
    .clk   (clk),
    .rst_n (rst_n),
    .i_ce  (w_accept),
    .i_d   (i_bank),
    .o_q   (w_bank_q)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state decode; rsp_ready only matters while in RESP
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (bus.req_valid) begin
          w_next_state = ST_ISSUE;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_ISSUE: w_next_state = ST_WAIT;
      ST_WAIT:  w_next_state = ST_RESP;
      ST_RESP: begin
        if (bus.rsp_ready) begin
          w_next_state = ST_IDLE;
        end else begin
          w_next_state = ST_RESP;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Request address, returned data and completion counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr_q   <= {ADDR_W{1'b0}};
      r_data_q   <= {DATA_W{1'b0}};
      r_rd_count <= {RD_CNT_W{1'b0}};
    end else begin
      if (w_accept) begin
        r_addr_q <= bus.req_addr;
      end
      if (r_state == ST_WAIT) begin
        r_data_q <= bus.mem_rdata;
      end
      if (w_rsp_done) begin
        r_rd_count <= r_rd_count + {{(RD_CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  // Outputs decode straight from state flops, so none are combinational on inputs
  assign bus.req_ready = (r_state == ST_IDLE);
  assign bus.mem_re    = (r_state == ST_ISSUE);
  assign bus.mem_addr  = {w_bank_q, r_addr_q};
  assign bus.rsp_valid = (r_state == ST_RESP);
  assign bus.rsp_data  = r_data_q;
  assign o_rd_count    = r_rd_count;

endmodule

// File: tb/tb_banked_mem_reader.sv
// Directed bench for banked_mem_reader with a one-cycle-latency memory model.
module tb_banked_mem_reader;

  logic       clk;
  logic       rst_n;
  logic [1:0] bank;
  logic [7:0] rd_count;
  int         n_checks;
  int         n_errors;
  int         mem_re_cnt;
  int         re_base;

  banked_mem_reader_if bus ();

  banked_mem_reader dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_bank     (bank),
    .bus        (bus),
    .o_rd_count (rd_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] mem_fn(input logic [7:0] a);
    return a ^ 8'hB9;
  endfunction

  // Synchronous memory: data valid the cycle after mem_re
  always @(posedge clk) begin
    if (bus.mem_re) begin
      bus.mem_rdata <= mem_fn(bus.mem_addr);
    end
  end

  // Count read strobes seen on clock edges
  always @(posedge clk) begin
    if (!rst_n) begin
      mem_re_cnt <= 0;
    end else if (bus.mem_re) begin
      mem_re_cnt <= mem_re_cnt + 1;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (got !== exp) begin
      n_errors = n_errors + 1;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_reset(input string tag);
    check_eq({tag, "_req_ready"}, 32'(bus.req_ready), 32'd1);
    check_eq({tag, "_mem_re"},    32'(bus.mem_re),    32'd0);
    check_eq({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
    check_eq({tag, "_rd_count"},  32'(rd_count),      32'd0);
    check_eq({tag, "_mem_addr"},  32'(bus.mem_addr),  32'd0);
    check_eq({tag, "_rsp_data"},  32'(bus.rsp_data),  32'd0);
  endtask

  initial begin
    n_checks      = 0;
    n_errors      = 0;
    rst_n         = 1'b0;
    bank          = 2'd0;
    bus.req_valid = 1'b0;
    bus.req_addr  = 6'd0;
    bus.rsp_ready = 1'b0;
    #2;
    check_idle_reset("rst");
    step();
    step();
    rst_n = 1'b1;

    // Basic read: bank 2, addr 5 -> phys 0x85, data 0x3C
    bank = 2'd2; bus.req_addr = 6'd5; bus.req_valid = 1'b1;
    step();
    check_eq("b_mem_re",    32'(bus.mem_re),    32'd1);
    check_eq("b_mem_addr",  32'(bus.mem_addr),  32'h85);
    check_eq("b_req_ready", 32'(bus.req_ready), 32'd0);
    bus.req_valid = 1'b0;
    step();
    check_eq("b_wait_re",   32'(bus.mem_re),    32'd0);
    check_eq("b_wait_rsp",  32'(bus.rsp_valid), 32'd0);
    step();
    check_eq("b_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    check_eq("b_rsp_data",  32'(bus.rsp_data),  32'h3C);
    bus.rsp_ready = 1'b1;
    step();
    check_eq("b_rd_count",  32'(rd_count),      32'd1);
    check_eq("b_idle_rdy",  32'(bus.req_ready), 32'd1);
    check_eq("b_idle_rsp",  32'(bus.rsp_valid), 32'd0);

    // Bank change after accept, rsp_ready held high outside RESP
    bank = 2'd1; bus.req_addr = 6'h2A; bus.req_valid = 1'b1;
    step();
    check_eq("k_mem_addr",  32'(bus.mem_addr),  32'h6A);
    bank = 2'd3; bus.req_valid = 1'b0;
    step();
    check_eq("k_wait_cnt",  32'(rd_count),      32'd1);
    step();
    check_eq("k_rsp_data",  32'(bus.rsp_data),  32'hD3);
    check_eq("k_rsp_cnt",   32'(rd_count),      32'd1);
    step();
    check_eq("k_rd_count",  32'(rd_count),      32'd2);
    check_eq("k_bank_held", 32'(bus.mem_addr),  32'h6A);

    // Back-pressure: response held for 5 cycles, no second accept
    bank = 2'd0; bus.req_addr = 6'h11; bus.req_valid = 1'b1; bus.rsp_ready = 1'b0;
    re_base = mem_re_cnt;
    step(); step(); step();
    for (int i = 0; i < 5; i++) begin
      step();
      check_eq("s_rsp_valid", 32'(bus.rsp_valid), 32'd1);
      check_eq("s_rsp_data",  32'(bus.rsp_data),  32'hA8);
      check_eq("s_req_ready", 32'(bus.req_ready), 32'd0);
    end
    check_eq("s_one_re",    32'(mem_re_cnt - re_base), 32'd1);
    bus.rsp_ready = 1'b1; bus.req_valid = 1'b0;
    step();
    check_eq("s_idle",      32'(bus.req_ready), 32'd1);
    check_eq("s_rd_count",  32'(rd_count),      32'd3);

    // Back-to-back: one accept every 4 cycles, no bypass from RESP
    bank = 2'd2; bus.req_addr = 6'd7; bus.req_valid = 1'b1;
    re_base = mem_re_cnt;
    for (int i = 0; i < 16; i++) begin
      step();
      check_eq("bb_mem_re",    32'(bus.mem_re),    32'(i % 4 == 0));
      check_eq("bb_rsp_valid", 32'(bus.rsp_valid), 32'(i % 4 == 2));
    end
    bus.req_valid = 1'b0;
    check_eq("bb_rd_count", 32'(rd_count),             32'd7);
    check_eq("bb_re_cnt",   32'(mem_re_cnt - re_base), 32'd4);

    // Wrap: 249 more reads take the count from 7 through 255 to 0
    bus.req_valid = 1'b1;
    re_base = mem_re_cnt;
    for (int i = 0; i < 249 * 4; i++) begin
      step();
    end
    bus.req_valid = 1'b0;
    check_eq("w_rd_count", 32'(rd_count),             32'd0);
    check_eq("w_re_cnt",   32'(mem_re_cnt - re_base), 32'd249);

    // Reset pulsed during WAIT
    bank = 2'd1; bus.req_addr = 6'd3; bus.req_valid = 1'b1; bus.rsp_ready = 1'b0;
    step();
    bus.req_valid = 1'b0;
    step();
    check_eq("r_in_wait", 32'(bus.mem_re), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check_idle_reset("ar");
    step();
    step();
    check_eq("ar_no_rsp", 32'(bus.rsp_valid), 32'd0);
    rst_n = 1'b1;
    step();
    check_eq("ar_still", 32'(bus.rsp_valid), 32'd0);
    bank = 2'd3; bus.req_addr = 6'h3F; bus.req_valid = 1'b1; bus.rsp_ready = 1'b1;
    step();
    check_eq("ar_mem_addr", 32'(bus.mem_addr), 32'hFF);
    check_eq("ar_mem_re",   32'(bus.mem_re),   32'd1);
    bus.req_valid = 1'b0;
    step();
    step();
    check_eq("ar_rsp_data", 32'(bus.rsp_data), 32'h46);
    step();
    check_eq("ar_rd_count", 32'(rd_count),     32'd1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
